// File: rtl/tmr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_ctrl_pkg
//  Purpose  : Shared constants and types for the TMR recovery controller.
//             - FSM state encodings (debug-visible on ctrl_state)
//             - Voter agreement pattern constants
//             - Core identifiers used on resync_core
//             - Decoded fault classification record
//  Revision : 1.0  initial release
// ============================================================================
package tmr_ctrl_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_RUN         = 3'd0;
    localparam logic [2:0] ST_RESYNC      = 3'd1;
    localparam logic [2:0] ST_ROLLBACK    = 3'd2;
    localparam logic [2:0] ST_HOLD_SETTLE = 3'd3;
    localparam logic [2:0] ST_FATAL       = 3'd4;

    // Voter agreement vector {A==B, B==C, A==C}
    localparam logic [2:0] AGREE = 3'b111;
    localparam logic [2:0] A_BAD = 3'b010;
    localparam logic [2:0] B_BAD = 3'b001;
    localparam logic [2:0] C_BAD = 3'b100;

    // Core identifiers
    localparam logic [1:0] CORE_A    = 2'd0;
    localparam logic [1:0] CORE_B    = 2'd1;
    localparam logic [1:0] CORE_C    = 2'd2;
    localparam logic [1:0] CORE_NONE = 2'd3;

    // One decoded voter sample
    typedef struct packed {
        logic       agree;      // all three cores agree
        logic       no_maj;     // no usable majority
        logic       bad_valid;  // exactly one core disagrees
        logic [1:0] bad_id;     // which core, CORE_NONE when !bad_valid
    } fault_class_t;

    // Counter width helper: never returns less than one bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_fault_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_fault_classifier
//  Purpose  : Combinational decode of the voter agreement vector.
//  Ports    : voter_state  in   3   {A==B, B==C, A==C}
//             fclass       out  --  {agree, no_maj, bad_valid, bad_id}
//  Revision : 1.0  initial release
// ============================================================================
module tmr_fault_classifier
    import tmr_ctrl_pkg::*;
(
    input  logic [2:0]   voter_state,
    output fault_class_t fclass
);

    // Patterns 011/101/110 are impossible with a consistent equality vector
    // (two equalities imply the third); they fall into the no-majority default
    // so the controller reacts conservatively.
    always_comb begin
        fclass.agree     = 1'b0;
        fclass.no_maj    = 1'b1;
        fclass.bad_valid = 1'b0;
        fclass.bad_id    = CORE_NONE;
        case (voter_state)
            AGREE: begin
                fclass.agree  = 1'b1;
                fclass.no_maj = 1'b0;
            end
            A_BAD: begin
                fclass.no_maj    = 1'b0;
                fclass.bad_valid = 1'b1;
                fclass.bad_id    = CORE_A;
            end
            B_BAD: begin
                fclass.no_maj    = 1'b0;
                fclass.bad_valid = 1'b1;
                fclass.bad_id    = CORE_B;
            end
            C_BAD: begin
                fclass.no_maj    = 1'b0;
                fclass.bad_valid = 1'b1;
                fclass.bad_id    = CORE_C;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tmr_recovery_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_recovery_ctrl
//  Purpose  : Supervisory FSM for triple-redundant cores. Keeps the last
//             fully agreed PC as checkpoint, resyncs a persistently faulty
//             core, rolls all cores back on loss of majority and escalates
//             to FATAL after bounded retries.
//  Ports    : clk, rst_in (async, active low)
//             voter_state[2:0], pc_top[31:0], resync_done, clear_fatal
//             core_hold, rollback_en, rollback_pc[31:0], resync_req,
//             resync_core[1:0], faulty_mask[2:0], fatal_err,
//             fault_count[CNT_W-1:0], ctrl_state[2:0]
//  Revision : 1.0  initial release
// ============================================================================
module tmr_recovery_ctrl
    import tmr_ctrl_pkg::*;
#(
    parameter int unsigned PERSIST_THRESH  = 4,
    parameter int unsigned ROLLBACK_CYCLES = 3,
    parameter int unsigned MAX_RETRY       = 2,
    parameter int unsigned CLEAN_CYCLES    = 8,
    parameter int unsigned CNT_W           = 16,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [2:0]       voter_state,
    input  logic [31:0]      pc_top,
    input  logic             resync_done,
    input  logic             clear_fatal,
    output logic             core_hold,
    output logic             rollback_en,
    output logic [31:0]      rollback_pc,
    output logic             resync_req,
    output logic [1:0]       resync_core,
    output logic [2:0]       faulty_mask,
    output logic             fatal_err,
    output logic [CNT_W-1:0] fault_count,
    output logic [2:0]       ctrl_state
);

    localparam int unsigned PW = clog2_min1(PERSIST_THRESH + 1);
    localparam int unsigned CW = clog2_min1(CLEAN_CYCLES + 1);
    localparam int unsigned RW = clog2_min1(MAX_RETRY + 1);
    localparam int unsigned BW = clog2_min1(ROLLBACK_CYCLES);

    localparam logic [PW-1:0] c_persist_thresh = PW'(PERSIST_THRESH);
    localparam logic [CW-1:0] c_clean_max      = CW'(CLEAN_CYCLES);
    localparam logic [RW-1:0] c_max_retry      = RW'(MAX_RETRY);
    // Down-counter runs LOAD..0 inclusive, giving ROLLBACK_CYCLES cycles
    localparam logic [BW-1:0] c_rb_load        = BW'(ROLLBACK_CYCLES - 1);

    fault_class_t fclass;

    tmr_fault_classifier u_classifier (
        .voter_state (voter_state),
        .fclass      (fclass)
    );

    logic [2:0]       state_q,       state_d;
    logic [31:0]      rollback_pc_q, rollback_pc_d;
    logic [PW-1:0]    persist_q,     persist_d;
    logic [1:0]       prev_bad_q,    prev_bad_d;
    logic [CW-1:0]    clean_q,       clean_d;
    logic [RW-1:0]    retry_q,       retry_d;
    logic [BW-1:0]    rb_cnt_q,      rb_cnt_d;
    logic [1:0]       resync_id_q,   resync_id_d;
    logic [2:0]       faulty_mask_q, faulty_mask_d;
    logic [CNT_W-1:0] fault_count_q, fault_count_d;
    logic             core_hold_q,   core_hold_d;
    logic             rollback_en_q, rollback_en_d;
    logic             resync_req_q,  resync_req_d;
    logic [1:0]       resync_core_q, resync_core_d;
    logic             fatal_err_q,   fatal_err_d;

    always_comb begin
        state_d       = state_q;
        rollback_pc_d = rollback_pc_q;
        persist_d     = persist_q;
        prev_bad_d    = prev_bad_q;
        clean_d       = clean_q;
        retry_d       = retry_q;
        rb_cnt_d      = rb_cnt_q;
        resync_id_d   = resync_id_q;
        faulty_mask_d = faulty_mask_q;
        fault_count_d = fault_count_q;

        case (state_q)
            ST_RUN: begin
                if (!fclass.agree && !(&fault_count_q)) begin
                    fault_count_d = fault_count_q + CNT_W'(1);
                end

                if (fclass.agree) begin
                    rollback_pc_d = pc_top;
                    persist_d     = '0;
                    if (clean_q != c_clean_max) begin
                        clean_d = clean_q + CW'(1);
                    end
                    if (clean_d == c_clean_max) begin
                        retry_d = '0;
                    end
                end else if (fclass.no_maj) begin
                    // Loss of majority outranks a pending single-core threshold
                    clean_d   = '0;
                    persist_d = '0;
                    if (retry_q == c_max_retry) begin
                        state_d = ST_FATAL;
                    end else begin
                        retry_d  = retry_q + RW'(1);
                        rb_cnt_d = c_rb_load;
                        state_d  = ST_ROLLBACK;
                    end
                end else begin
                    clean_d    = '0;
                    prev_bad_d = fclass.bad_id;
                    // After an agree/rollback persist is 0, so +1 also covers
                    // the "fresh fault" case for a repeated core id.
                    if (fclass.bad_id == prev_bad_q) begin
                        persist_d = persist_q + PW'(1);
                    end else begin
                        persist_d = PW'(1);
                    end
                    if (persist_d >= c_persist_thresh) begin
                        faulty_mask_d = faulty_mask_q | (3'b001 << fclass.bad_id);
                        resync_id_d   = fclass.bad_id;
                        // Fault is being handled; restart persistence tracking
                        persist_d     = '0;
                        state_d       = ST_RESYNC;
                    end
                end
            end

            ST_RESYNC: begin
                if (resync_done) begin
                    state_d = ST_RUN;
                end
            end

            ST_ROLLBACK: begin
                if (rb_cnt_q == '0) begin
                    state_d = ST_HOLD_SETTLE;
                end else begin
                    rb_cnt_d = rb_cnt_q - BW'(1);
                end
            end

            ST_HOLD_SETTLE: begin
                state_d = ST_RUN;
            end

            ST_FATAL: begin
                if (clear_fatal) begin
                    retry_d   = '0;
                    persist_d = '0;
                    state_d   = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Control outputs are a function of the next state, then registered
        core_hold_d   = (state_d != ST_RUN);
        rollback_en_d = (state_d == ST_ROLLBACK);
        resync_req_d  = (state_d == ST_RESYNC);
        resync_core_d = (state_d == ST_RESYNC) ? resync_id_d : CORE_NONE;
        fatal_err_d   = (state_d == ST_FATAL);
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= ST_RUN;
            rollback_pc_q <= RESET_PC;
            persist_q     <= '0;
            prev_bad_q    <= CORE_NONE;
            clean_q       <= '0;
            retry_q       <= '0;
            rb_cnt_q      <= '0;
            resync_id_q   <= CORE_NONE;
            faulty_mask_q <= '0;
            fault_count_q <= '0;
            core_hold_q   <= 1'b0;
            rollback_en_q <= 1'b0;
            resync_req_q  <= 1'b0;
            resync_core_q <= CORE_NONE;
            fatal_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rollback_pc_q <= rollback_pc_d;
            persist_q     <= persist_d;
            prev_bad_q    <= prev_bad_d;
            clean_q       <= clean_d;
            retry_q       <= retry_d;
            rb_cnt_q      <= rb_cnt_d;
            resync_id_q   <= resync_id_d;
            faulty_mask_q <= faulty_mask_d;
            fault_count_q <= fault_count_d;
            core_hold_q   <= core_hold_d;
            rollback_en_q <= rollback_en_d;
            resync_req_q  <= resync_req_d;
            resync_core_q <= resync_core_d;
            fatal_err_q   <= fatal_err_d;
        end
    end

    assign core_hold   = core_hold_q;
    assign rollback_en = rollback_en_q;
    assign rollback_pc = rollback_pc_q;
    assign resync_req  = resync_req_q;
    assign resync_core = resync_core_q;
    assign faulty_mask = faulty_mask_q;
    assign fatal_err   = fatal_err_q;
    assign fault_count = fault_count_q;
    assign ctrl_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_recovery_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_recovery_ctrl
//  Purpose  : Self-checking bench for tmr_recovery_ctrl. Stimulus is driven
//             on the falling edge; a rule-level reference model predicts the
//             outputs after the next rising edge and queues them; a monitor
//             pops and compares each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tmr_recovery_ctrl;

    localparam int P_THRESH = 4;
    localparam int P_RB     = 3;
    localparam int P_RETRY  = 2;
    localparam int P_CLEAN  = 8;
    localparam int P_CNT_W  = 16;
    localparam logic [31:0] P_RESET_PC = 32'h0;

    localparam int M_RUN = 0, M_RESYNC = 1, M_ROLLBACK = 2, M_SETTLE = 3, M_FATAL = 4;

    logic         clk = 1'b0;
    logic         rst_in = 1'b0;
    logic [2:0]   voter_state = 3'b111;
    logic [31:0]  pc_top = 32'h0;
    logic         resync_done = 1'b0;
    logic         clear_fatal = 1'b0;
    logic         core_hold, rollback_en, resync_req, fatal_err;
    logic [31:0]  rollback_pc;
    logic [1:0]   resync_core;
    logic [2:0]   faulty_mask, ctrl_state;
    logic [15:0]  fault_count;

    always #5 clk = ~clk;

    tmr_recovery_ctrl #(
        .PERSIST_THRESH  (P_THRESH),
        .ROLLBACK_CYCLES (P_RB),
        .MAX_RETRY       (P_RETRY),
        .CLEAN_CYCLES    (P_CLEAN),
        .CNT_W           (P_CNT_W),
        .RESET_PC        (P_RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .voter_state (voter_state),
        .pc_top      (pc_top),
        .resync_done (resync_done),
        .clear_fatal (clear_fatal),
        .core_hold   (core_hold),
        .rollback_en (rollback_en),
        .rollback_pc (rollback_pc),
        .resync_req  (resync_req),
        .resync_core (resync_core),
        .faulty_mask (faulty_mask),
        .fatal_err   (fatal_err),
        .fault_count (fault_count),
        .ctrl_state  (ctrl_state)
    );

    typedef struct packed {
        logic        core_hold;
        logic        rollback_en;
        logic [31:0] rollback_pc;
        logic        resync_req;
        logic [1:0]  resync_core;
        logic [2:0]  faulty_mask;
        logic        fatal_err;
        logic [15:0] fault_count;
        logic [2:0]  ctrl_state;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // ---------------- reference model (rule level) ----------------
    int          m_mode, m_persist, m_last, m_clean, m_retry, m_rb_left, m_rs_id, m_mask, m_fcount;
    logic [31:0] m_ckpt;

    task automatic model_reset();
        m_mode = M_RUN; m_persist = 0; m_last = -1; m_clean = 0; m_retry = 0;
        m_rb_left = 0; m_rs_id = 3; m_mask = 0; m_fcount = 0; m_ckpt = P_RESET_PC;
    endtask

    task automatic model_step(input logic [2:0] vs, input logic [31:0] pc,
                              input logic done, input logic clr);
        int id;
        case (m_mode)
            M_RUN: begin
                if (vs == 3'b111) begin
                    m_ckpt    = pc;
                    m_persist = 0;
                    if (m_clean < P_CLEAN) m_clean++;
                    if (m_clean == P_CLEAN) m_retry = 0;
                end else begin
                    if (m_fcount < (1 << P_CNT_W) - 1) m_fcount++;
                    id = (vs == 3'b010) ? 0 : (vs == 3'b001) ? 1 : (vs == 3'b100) ? 2 : -1;
                    m_clean = 0;
                    if (id < 0) begin
                        m_persist = 0;
                        if (m_retry == P_RETRY) m_mode = M_FATAL;
                        else begin
                            m_retry++;
                            m_rb_left = P_RB;
                            m_mode    = M_ROLLBACK;
                        end
                    end else begin
                        m_persist = (id == m_last) ? m_persist + 1 : 1;
                        m_last    = id;
                        if (m_persist >= P_THRESH) begin
                            m_mask    = m_mask | (1 << id);
                            m_rs_id   = id;
                            m_persist = 0;
                            m_mode    = M_RESYNC;
                        end
                    end
                end
            end
            M_RESYNC:   if (done) m_mode = M_RUN;
            M_ROLLBACK: begin
                m_rb_left--;
                if (m_rb_left == 0) m_mode = M_SETTLE;
            end
            M_SETTLE:   m_mode = M_RUN;
            default: if (clr) begin
                m_mode = M_RUN; m_retry = 0; m_persist = 0;
            end
        endcase
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.core_hold   = (m_mode != M_RUN);
        e.rollback_en = (m_mode == M_ROLLBACK);
        e.rollback_pc = m_ckpt;
        e.resync_req  = (m_mode == M_RESYNC);
        e.resync_core = (m_mode == M_RESYNC) ? 2'(m_rs_id) : 2'd3;
        e.faulty_mask = 3'(m_mask);
        e.fatal_err   = (m_mode == M_FATAL);
        e.fault_count = 16'(m_fcount);
        e.ctrl_state  = 3'(m_mode);
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e);
        check_field("core_hold",   32'(core_hold),   32'(e.core_hold));
        check_field("rollback_en", 32'(rollback_en), 32'(e.rollback_en));
        check_field("rollback_pc", rollback_pc,      e.rollback_pc);
        check_field("resync_req",  32'(resync_req),  32'(e.resync_req));
        check_field("resync_core", 32'(resync_core), 32'(e.resync_core));
        check_field("faulty_mask", 32'(faulty_mask), 32'(e.faulty_mask));
        check_field("fatal_err",   32'(fatal_err),   32'(e.fatal_err));
        check_field("fault_count", 32'(fault_count), 32'(e.fault_count));
        check_field("ctrl_state",  32'(ctrl_state),  32'(e.ctrl_state));
    endtask

    // Monitor: one registered response per rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow actual=empty required=entry t=%0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    compare_all(e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_step(input logic [2:0] vs, input logic [31:0] pc,
                              input logic done, input logic clr);
        voter_state = vs;
        pc_top      = pc;
        resync_done = done;
        clear_fatal = clr;
        model_step(vs, pc, done, clr);
        sb_q.push_back(model_outputs());
    endtask

    task automatic cycle(input logic [2:0] vs, input logic [31:0] pc,
                         input logic done = 1'b0, input logic clr = 1'b0);
        @(negedge clk);
        drive_step(vs, pc, done, clr);
    endtask

    // Reset asserted between edges; outputs must already be at reset values
    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        rst_in = 1'b0;
        #1;
        model_reset();
        compare_all(model_outputs());
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        mon_en = 1'b1;
        drive_step(3'b111, 32'h0, 1'b0, 1'b0);
    endtask

    logic [2:0] nomaj_pats [4] = '{3'b000, 3'b011, 3'b101, 3'b110};
    logic [2:0] single_pats[3] = '{3'b010, 3'b001, 3'b100};
    logic [2:0] burst_pat;
    logic [2:0] rvs;
    logic       rd, rc;
    int         burst_left;
    int         r;

    initial begin
        burst_left = 0;
        burst_pat  = 3'b111;
        model_reset();

        // Checkpoint tracking
        do_reset();
        cycle(3'b111, 32'h4);
        cycle(3'b111, 32'h8);

        // Persistent core A fault -> resync, then release
        repeat (4) cycle(3'b010, 32'hDEAD_0000);
        cycle(3'b010, 32'h1);
        cycle(3'b111, 32'h2, 1'b1);
        cycle(3'b111, 32'hC);

        // Core change restarts persistence: only B gets flagged
        cycle(3'b010, 32'h10);
        cycle(3'b010, 32'h14);
        repeat (4) cycle(3'b001, 32'h18);
        cycle(3'b000, 32'h1C);
        cycle(3'b111, 32'h20, 1'b1);

        // Rollback to checkpoint 0x40, checkpoint frozen meanwhile
        cycle(3'b111, 32'h40);
        cycle(3'b000, 32'h44);
        repeat (6) cycle(3'b111, 32'h99);

        // Repeated loss of majority with short clean gaps -> FATAL
        cycle(3'b000, 32'h50);
        repeat (5) cycle(3'b111, 32'h54);
        cycle(3'b110, 32'h58);
        repeat (5) cycle(3'b111, 32'h5C);
        cycle(3'b000, 32'h60);
        repeat (3) cycle(3'b111, 32'h64);
        cycle(3'b111, 32'h68, 1'b0, 1'b1);
        repeat (2) cycle(3'b111, 32'h6C);

        // Same events with long clean gaps -> no FATAL
        for (int k = 0; k < 3; k++) begin
            cycle(3'b000, 32'h70);
            repeat (5 + P_CLEAN) cycle(3'b111, 32'h74 + 32'(k * 4));
        end

        // Stray pulses outside their states are ignored
        cycle(3'b111, 32'h80, 1'b1, 1'b1);

        // Reset during the second rollback cycle
        cycle(3'b111, 32'h123);
        cycle(3'b000, 32'h124);
        cycle(3'b111, 32'h128);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rd = 1'b0;
            rc = 1'b0;
            r  = $urandom_range(0, 99);
            if (m_mode == M_RUN) begin
                if (burst_left > 0) begin
                    rvs = burst_pat;
                    burst_left--;
                end else if (r < 62) begin
                    rvs = 3'b111;
                end else if (r < 92) begin
                    burst_pat  = single_pats[$urandom_range(0, 2)];
                    burst_left = $urandom_range(0, 5);
                    rvs        = burst_pat;
                end else begin
                    rvs = nomaj_pats[$urandom_range(0, 3)];
                end
            end else begin
                rvs = 3'($urandom_range(0, 7));
            end
            if (m_mode == M_RESYNC)     rd = ($urandom_range(0, 3) == 0);
            else if (m_mode == M_FATAL) rc = ($urandom_range(0, 2) == 0);
            else begin
                rd = ($urandom_range(0, 19) == 0);
                rc = ($urandom_range(0, 19) == 0);
            end
            cycle(rvs, $urandom & 32'hFFFF_FFFC, rd, rc);
            if (n % 997 == 500) do_reset();
        end

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
